// File: rtl/wb_burst_arbiter.sv
// Two-master Wishbone arbiter in front of one shared slave port.
// A grant is held for the master's whole cyc (bursts included). Contention is
// resolved round-robin. A stalled-strobe watchdog answers the owner with a
// one-cycle error.
module wb_burst_arbiter #(
   parameter int unsigned ADR_W   = 30,
   parameter int unsigned DAT_W   = 32,
   parameter int unsigned SEL_W   = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,

   // master 0
   input  logic [ADR_W-1:0] m0_adr,
   input  logic [DAT_W-1:0] m0_dat_w,
   output logic [DAT_W-1:0] m0_dat_r,
   input  logic             m0_cyc,
   input  logic             m0_stb,
   input  logic             m0_we,
   input  logic [SEL_W-1:0] m0_sel,
   input  logic [2:0]       m0_cti,
   input  logic [1:0]       m0_bte,
   output logic             m0_ack,
   output logic             m0_err,

   // master 1
   input  logic [ADR_W-1:0] m1_adr,
   input  logic [DAT_W-1:0] m1_dat_w,
   output logic [DAT_W-1:0] m1_dat_r,
   input  logic             m1_cyc,
   input  logic             m1_stb,
   input  logic             m1_we,
   input  logic [SEL_W-1:0] m1_sel,
   input  logic [2:0]       m1_cti,
   input  logic [1:0]       m1_bte,
   output logic             m1_ack,
   output logic             m1_err,

   // shared slave
   output logic [ADR_W-1:0] s_adr,
   output logic [DAT_W-1:0] s_dat_w,
   input  logic [DAT_W-1:0] s_dat_r,
   output logic [SEL_W-1:0] s_sel,
   output logic             s_cyc,
   output logic             s_stb,
   output logic             s_we,
   output logic [2:0]       s_cti,
   output logic [1:0]       s_bte,
   input  logic             s_ack,
   input  logic             s_err,

   output logic [1:0]       grant
);

   localparam int unsigned CNT_W = 10;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             owner;
   logic             owner_nxt;
   logic             last_srv;
   logic             last_srv_nxt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] stall_cnt_nxt;

   logic             own_cyc;
   logic             own_stb;
   logic             busy;
   logic             timeout_hit;

   // State, owner, round-robin history and stall counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= 1'b0;
         last_srv  <= 1'b1;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         last_srv  <= last_srv_nxt;
         stall_cnt <= stall_cnt_nxt;
      end
   end

   // Owner's cyc/stb and watchdog condition; timeout is ignored once cyc drops
   always_comb begin
      busy        = (state == BUSY);
      own_cyc     = owner ? m1_cyc : m0_cyc;
      own_stb     = owner ? m1_stb : m0_stb;
      timeout_hit = busy && own_cyc && (stall_cnt == CNT_W'(TIMEOUT));
   end

   // Next-state logic: arbitration in IDLE, release and stall counting in BUSY
   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      last_srv_nxt  = last_srv;
      stall_cnt_nxt = stall_cnt;

      case (state)
         IDLE: begin
            stall_cnt_nxt = '0;
            if (m0_cyc && m1_cyc) begin
               owner_nxt = ~last_srv;
               state_nxt = BUSY;
            end else if (m0_cyc) begin
               owner_nxt = 1'b0;
               state_nxt = BUSY;
            end else if (m1_cyc) begin
               owner_nxt = 1'b1;
               state_nxt = BUSY;
            end
         end

         BUSY: begin
            if (!own_cyc) begin
               // always pass through IDLE so a new owner starts a cycle later
               state_nxt     = IDLE;
               last_srv_nxt  = owner;
               stall_cnt_nxt = '0;
            end else if (timeout_hit || s_ack || s_err || !own_stb) begin
               stall_cnt_nxt = '0;
            end else begin
               stall_cnt_nxt = stall_cnt + CNT_W'(1);
            end
         end

         default: begin
            state_nxt     = IDLE;
            stall_cnt_nxt = '0;
         end
      endcase
   end

   // Slave-side mux from the owner; everything quiet while IDLE
   always_comb begin
      s_adr   = '0;
      s_dat_w = '0;
      s_sel   = '0;
      s_we    = 1'b0;
      s_cti   = '0;
      s_bte   = '0;
      s_cyc   = 1'b0;
      s_stb   = 1'b0;

      if (busy) begin
         s_adr   = owner ? m1_adr   : m0_adr;
         s_dat_w = owner ? m1_dat_w : m0_dat_w;
         s_sel   = owner ? m1_sel   : m0_sel;
         s_we    = owner ? m1_we    : m0_we;
         s_cti   = owner ? m1_cti   : m0_cti;
         s_bte   = owner ? m1_bte   : m0_bte;
         s_cyc   = own_cyc;
         // strobe is withheld during the watchdog error cycle
         s_stb   = own_cyc && own_stb && !timeout_hit;
      end
   end

   // Responses go only to the owner; the non-owner sees all zeros
   always_comb begin
      m0_ack   = 1'b0;
      m0_err   = 1'b0;
      m0_dat_r = '0;
      m1_ack   = 1'b0;
      m1_err   = 1'b0;
      m1_dat_r = '0;

      if (busy) begin
         if (owner) begin
            m1_ack   = s_ack;
            m1_err   = s_err || timeout_hit;
            m1_dat_r = s_dat_r;
         end else begin
            m0_ack   = s_ack;
            m0_err   = s_err || timeout_hit;
            m0_dat_r = s_dat_r;
         end
      end
   end

   // One-hot owner indication
   always_comb begin
      grant = 2'b00;
      if (busy) begin
         grant = owner ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: doc/wb_burst_arbiter.md
WB_BURST_ARBITER -- requirements
Module: wb_burst_arbiter

Interface
REQ-001 Parameter ADR_W, default 30, Wishbone word-address width.
REQ-002 Parameter DAT_W, default 32, data width.
REQ-003 Parameter SEL_W, default 4, byte-select width.
REQ-004 Parameter TIMEOUT, default 255, max stalled-strobe cycles before error (range 1..1023).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 mN_adr  in  ADR_W  master N address (N = 0, 1; likewise for all mN_ ports).
REQ-008 mN_dat_w  in  DAT_W  master N write data.
REQ-009 mN_dat_r  out  DAT_W  read data to master N.
REQ-010 mN_cyc, mN_stb, mN_we  in  1 each  master N cycle, strobe, write enable.
REQ-011 mN_sel  in  SEL_W  master N byte selects.
REQ-012 mN_cti  in  3; mN_bte  in  2  master N burst cycle type and burst type.
REQ-013 mN_ack, mN_err  out  1 each  acknowledge and error to master N.
REQ-014 s_adr, s_dat_w, s_sel, s_cyc, s_stb, s_we, s_cti, s_bte  out  widths as master side  shared slave port.
REQ-015 s_dat_r  in  DAT_W; s_ack, s_err  in  1 each  slave responses.
REQ-016 grant  out  2  one-hot current owner (bit N = master N); 2'b00 when idle.

Function
REQ-017 States IDLE and BUSY plus an owner register; BUSY lasts from grant until the owner drops cyc.
REQ-018 IDLE: if only one mN_cyc is high, that master is granted on the next edge.
REQ-019 IDLE with both cyc high: grant the master not served last (round-robin); last-served register resets to 1, so m0 wins the first contention.
REQ-020 Arbitration latency is exactly one cycle: the slave sees the owner's strobe no earlier than the cycle after cyc rises.
REQ-021 BUSY: s_adr, s_dat_w, s_sel, s_we, s_cti and s_bte mux combinationally from the owner; s_cyc = owner cyc; s_stb = owner cyc AND owner stb.
REQ-022 IDLE: every s_* output is 0.
REQ-023 The owner's mN_ack, mN_err and mN_dat_r follow s_ack, s_err and s_dat_r combinationally (zero added latency).
REQ-024 The non-owner's ack and err are always 0; its dat_r is 0.
REQ-025 The grant is held for the whole cycle, including incrementing bursts (cti 3'b010) and end-of-burst (cti 3'b111). The arbiter never preempts on cti.
REQ-026 BUSY with owner cyc = 0: s_cyc is 0 that cycle; next state is IDLE and last-served is set to the owner.
REQ-027 IDLE lasts at least one cycle between owners (no same-edge handover).
REQ-028 Stall counter (10 bits):
- increments each BUSY cycle where s_stb = 1, s_ack = 0 and s_err = 0;
- clears on s_ack, on s_err, on s_stb = 0, and in IDLE.
REQ-029 When the stall counter equals TIMEOUT:
- pulse the owner's mN_err for exactly one cycle, with s_stb forced to 0 that cycle;
- clear the counter.
- Ownership is retained until the owner drops cyc.
REQ-030 If s_ack and s_err are both 1, both are forwarded to the owner unchanged; the arbiter does not resolve slave protocol errors.
REQ-031 A requester dropping cyc while not granted has no effect on state.

Reset
REQ-032 While reset is high at an edge, the next state is:
- state IDLE, owner 0, last-served 1, stall counter 0;
- grant = 2'b00, and all s_* and mN_* outputs 0.
REQ-033 Reset asserted mid-burst aborts the cycle: s_cyc is 0 in the cycle after the reset edge, with no error pulse issued.
REQ-034 After reset deasserts, arbitration resumes from IDLE on the next edge.

Verification
REQ-035 Single master: m0 reads 4-beat incrementing burst (cti 010,010,010,111) at adr 0x10, slave acks each cycle -> grant = 01 one cycle after m0_cyc, 4 m0_ack pulses, m1_ack = 0 throughout.
REQ-036 Contention: m0 and m1 raise cyc on the same edge after reset -> m0 granted first; after m0 drops cyc, one IDLE cycle, then grant = 10.
REQ-037 Round-robin: m1 then m0 served, then both request simultaneously -> m1 granted (last served was m0).
REQ-038 Timeout with TIMEOUT = 8: slave never acks m0 strobe -> m0_err high for exactly one cycle, 9 cycles after the first stb cycle; grant stays 01 until m0_cyc drops.
REQ-039 Reset at beat 2 of a 4-beat m1 write burst -> grant = 00 and s_cyc = 0 the next cycle; a subsequent m0-only request is granted normally.
REQ-040 Non-owner isolation: m1 strobes continuously while m0 owns -> m1_ack = m1_err = 0 and s_adr equals m0_adr in every BUSY cycle.
